mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter and sequencer for the single shared data/instruction memory of the RISCBlade multicycle core. Port 0 serves the processor's memory accesses (fetch, lw, sw), and port 1 serves an auxiliary requester such as a program loader or debug port. Each access runs a fixed IDLE→ISSUE→DONE sequence against a synchronous memory with 1-cycle read latency. Simultaneous requests are resolved round-robin.

## Interface
- DATA_W, 16, data width of memory and ports
- ADDR_W, 16, address width of memory and ports
- CLK  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req0 / req1  in  1  access request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- ack0 / ack1  out  1  one-cycle pulse, access complete
- rdata  out  DATA_W  read data, valid while the granted port's ack is high
- busy  out  1  high in ISSUE and DONE
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0

## Operation
- FSM states:
  - IDLE (reset state)
  - ISSUE
  - DONE
- IDLE transitions:
  - No req: stay in IDLE.
  - Any req: select a port, latch its we/addr/wdata into internal registers and record grant (0/1), go to ISSUE.
- ISSUE:
  - mem_en=1; mem_addr/mem_wdata driven from the latched registers; mem_we=latched we.
  - Go to DONE unconditionally.
- DONE:
  - Pulse the granted port's ack (ack0 or ack1).
  - On reads, rdata is captured from mem_rdata and held until the next DONE.
  - last_grant←grant; go to IDLE.
- Arbitration is evaluated in IDLE only:
  - One req high: grant that port.
  - Both high: grant the port ≠ last_grant.
  - last_grant resets to 1, so port 0 wins the first tie.
- Request inputs are sampled only in IDLE. Changes to we/addr/wdata after the IDLE sampling edge have no effect on the access in flight.
- Requester rule: hold req until ack. req still high in the cycle after ack is treated as a new request.
- Outputs outside ISSUE: mem_en=0, mem_we=0, mem_addr/mem_wdata hold their latched values.
- Never both ack0 and ack1 in the same cycle; never more than one access in flight.
- No address or data transformation; widths pass straight through.

## Timing
- Reset values:
  - state=IDLE, last_grant=1
  - ack0=ack1=0, busy=0, mem_en=0, mem_we=0
  - rdata=0, mem_addr=0, mem_wdata=0
- Latency: req sampled at edge N (state IDLE) → ISSUE during cycle N+1 → ack high during cycle N+2 → IDLE again at N+3.
- Throughput: one access per 3 cycles per arbiter, back-to-back allowed.
- Under continuous contention both ports alternate; each port waits at most one access (3 cycles) beyond its own.
- Reset mid-operation (ISSUE or DONE): immediate return to IDLE. The access is aborted with no ack, and mem_we deasserts asynchronously. A write already applied to memory at a prior edge is not undone.
- Request dropped before ack: the access still completes and ack still pulses (arbiter does not cancel).

## Test plan
- Single read, port 0:
  - Stimulus: mem preloaded [0x0010]=0xBEEF; req0=1, we0=0, addr0=0x0010 at cycle 0.
  - Response: mem_en=1/mem_we=0/mem_addr=0x0010 in cycle 1; ack0=1 and rdata=0xBEEF in cycle 2; ack1 never asserts.
- Single write, port 1:
  - Stimulus: req1, we1=1, addr1=0x0020, wdata1=0x1234.
  - Response: mem_we=1 for exactly one cycle with mem_addr=0x0020, mem_wdata=0x1234; ack1 two cycles after sampling; read-back via port 0 returns 0x1234.
- Tie after reset:
  - Stimulus: req0 and req1 both held high continuously.
  - Response: grant order 0,1,0,1; acks at cycles 2,5,8,11 alternating ack0/ack1.
- Input change during access:
  - Stimulus: after the port 0 sampling edge, change addr0 from 0x0030 to 0x0040.
  - Response: mem_addr=0x0030 in ISSUE.
- Reset in ISSUE:
  - Stimulus: assert reset during ISSUE of a port 1 write.
  - Response: mem_we=0 and busy=0 immediately; no ack1; after release, a pending req0 is granted first (tie→0).
- Early drop:
  - Stimulus: req0 deasserted in the ISSUE cycle.
  - Response: ack0 still pulses in the following cycle; FSM returns to IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of requester-side and memory-side signals of the
//               two-port shared-memory arbiter.
//               slave  - the arbiter's view.
//               master - the requesters plus the memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin two-port arbiter and IDLE->ISSUE->DONE sequencer
//               for a synchronous memory with 1-cycle read latency.
//               Port 0 is the core, port 1 an auxiliary requester.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  wire          CLK,
    input  wire          reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q,      state_d;
    logic              grant_q,      grant_d;
    logic              last_grant_q, last_grant_d;
    logic              we_q,         we_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic [DATA_W-1:0] rdata_q,      rdata_d;
    logic              ack0_q,       ack0_d;
    logic              ack1_q,       ack1_d;
    logic              busy_q,       busy_d;
    logic              mem_en_q,     mem_en_d;
    logic              mem_we_q,     mem_we_d;
    logic              pick1;

    // Next-state logic: arbitration and request latching happen only in IDLE;
    // strobes are computed one state ahead so they come straight from flops.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        busy_d       = 1'b0;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        // Port 1 wins when alone, or on a tie when port 0 was served last.
        pick1        = bus.req1 && (!bus.req0 || (last_grant_q == 1'b0));

        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant_d  = pick1;
                    we_d     = pick1 ? bus.we1    : bus.we0;
                    addr_d   = pick1 ? bus.addr1  : bus.addr0;
                    wdata_d  = pick1 ? bus.wdata1 : bus.wdata0;
                    state_d  = S_ISSUE;
                    busy_d   = 1'b1;
                    mem_en_d = 1'b1;
                    mem_we_d = pick1 ? bus.we1 : bus.we0;
                end
            end
            S_ISSUE: begin
                state_d = S_DONE;
                busy_d  = 1'b1;
                ack0_d  = (grant_q == 1'b0);
                ack1_d  = (grant_q == 1'b1);
            end
            S_DONE: begin
                state_d      = S_IDLE;
                last_grant_d = grant_q;
                if (!we_q) begin
                    rdata_d = bus.mem_rdata;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight at once.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.busy      = busy_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    // Read data arrives during DONE, the same cycle as ack, so it is passed
    // through then and held from the capture register afterwards.
    assign bus.rdata     = ((state_q == S_DONE) && !we_q) ? bus.mem_rdata : rdata_q;

endmodule
`default_nettype wire
